// File: rtl/store_buffer.sv
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

// Store buffer: DEPTH-entry FIFO of core stores drained to memory with load forwarding; SB_COALESCE_EN merges repeat stores.
// Latency: a store forwards to loads from the next cycle, mem_req rises the edge after enqueue, ddin is combinational.
// Backpressure: none toward the core; a store arriving full with no drain that cycle is dropped and sets sticky overflow.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = `WORD_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        daddr,
    input  logic                 dwr,
    input  logic [`WORD_LEN-1:0] ddout,
    output logic [`WORD_LEN-1:0] ddin,
    output logic                 sb_full,
    output logic                 sb_empty,
    output logic                 overflow,
    output logic                 mem_req,
    output logic [AW-1:0]        mem_addr,
    output logic [`WORD_LEN-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [`WORD_LEN-1:0] mem_rdata
);
    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

    typedef enum logic {IDLE, REQ} state_t;
    state_t state_q, state_d;

    logic [AW-1:0]        addr_q [DEPTH];
    logic [`WORD_LEN-1:0] data_q [DEPTH];
    logic [PW-1:0]        head_q, tail_q;
    logic [PW:0]          count_q;
    logic                 overflow_q;

    logic [PW-1:0]        slot [DEPTH];
    logic [DEPTH-1:0]     ent_hit;
    logic                 pop, enq, drop, coal_hit;

    // slot[i] is the i-th oldest entry; ent_hit flags valid entries matching the core address
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot[i]    = head_q + PW'(i);
            ent_hit[i] = ((PW+1)'(i) < count_q) && (addr_q[head_q + PW'(i)] == daddr);
        end
    end

    // Newest match wins; uses pre-edge state so a same-cycle store or pop does not affect it
    always_comb begin
        ddin = mem_rdata;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_hit[i]) begin
                ddin = data_q[slot[i]];
            end
        end
    end

`ifdef SB_COALESCE_EN
    logic [PW-1:0] coal_idx;

    // The head is skipped because it may already be in flight to memory
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = tail_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (ent_hit[i]) begin
                coal_hit = dwr;
                coal_idx = slot[i];
            end
        end
    end
`else
    assign coal_hit = 1'b0;
`endif

    assign pop  = (state_q == REQ) && mem_ack;
    assign enq  = dwr && !coal_hit && ((count_q != FULL_CNT) || pop);
    assign drop = dwr && !coal_hit && (count_q == FULL_CNT) && !pop;

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (pop && !enq && (count_q == ONE_CNT)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (enq) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Payload is never reset; validity comes solely from count_q
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= daddr;
            data_q[tail_q] <= ddout;
        end
`ifdef SB_COALESCE_EN
        else if (coal_hit) begin
            data_q[coal_idx] <= ddout;
        end
`endif
    end

    assign mem_addr  = addr_q[head_q];
    assign mem_wdata = data_q[head_q];
    assign sb_full   = (count_q == FULL_CNT);
    assign sb_empty  = (count_q == '0);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_store_buffer.sv
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

// Directed bench for store_buffer (DEPTH=4): drain timing, overflow, forwarding, async reset, coalescing.
module tb_store_buffer;
    localparam int W = `WORD_LEN;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] daddr;
    logic         dwr;
    logic [W-1:0] ddout;
    logic [W-1:0] ddin;
    logic         sb_full;
    logic         sb_empty;
    logic         overflow;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_ack;
    logic [W-1:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    store_buffer #(.DEPTH(4), .AW(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .daddr     (daddr),
        .dwr       (dwr),
        .ddout     (ddout),
        .ddin      (ddin),
        .sb_full   (sb_full),
        .sb_empty  (sb_empty),
        .overflow  (overflow),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [W-1:0] a, input logic [W-1:0] d);
        daddr = a;
        ddout = d;
        dwr   = 1'b1;
        tick();
        dwr   = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        dwr     = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    logic [W-1:0] ea[$];
    logic [W-1:0] ed[$];

    initial begin
        rst       = 1'b0;
        dwr       = 1'b0;
        daddr     = '0;
        ddout     = '0;
        mem_ack   = 1'b0;
        mem_rdata = 'hFF;
        tick();
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_empty", sb_empty, 1);
        check("rst_full", sb_full, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b1;

        // Single store: request appears one edge after enqueue and holds while unacked
        store('h10, 'h11);
        check("enq_not_empty", sb_empty, 0);
        check("enq_req_low", mem_req, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("hold_req", mem_req, 1);
            check("hold_addr", mem_addr, 'h10);
            check("hold_data", mem_wdata, 'h11);
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("drain1_req", mem_req, 0);
        check("drain1_empty", sb_empty, 1);

        // Forwarding: newest duplicate wins, miss falls through, same-cycle store not seen
        store('h20, 'hA);
        store('h20, 'hB);
        daddr = 'h20;
        #1 check("fwd_newest", ddin, 'hB);
        daddr = 'h21;
        #1 check("fwd_miss", ddin, 'hFF);
        daddr = 'h20;
        ddout = 'hC;
        dwr   = 1'b1;
        #1 check("fwd_pre_enq", ddin, 'hB);
        tick();
        dwr = 1'b0;
        check("fwd_post_enq", ddin, 'hC);
        mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("dup_addr", mem_addr, 'h20);
            check("dup_data", mem_wdata, W'('hA + k));
            tick();
        end
        mem_ack = 1'b0;
        check("dup_empty", sb_empty, 1);
        check("dup_req", mem_req, 0);

        // Full buffer: store plus drain in one cycle is accepted, a later store is dropped
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            store(W'(k), W'('h100 + k));
        end
        check("fill_full", sb_full, 1);
        check("fill_ovf", overflow, 0);
        check("fill_head", mem_addr, 'h1);
        daddr   = 'h6;
        ddout   = 'h106;
        dwr     = 1'b1;
        mem_ack = 1'b1;
        tick();
        dwr     = 1'b0;
        mem_ack = 1'b0;
        check("swap_full", sb_full, 1);
        check("swap_ovf", overflow, 0);
        check("swap_head", mem_addr, 'h2);
        store('h5, 'h105);
        check("drop_ovf", overflow, 1);
        check("drop_full", sb_full, 1);
        ea = '{'h2, 'h3, 'h4, 'h6};
        mem_ack = 1'b1;
        daddr   = 'h2;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                #1 check("fwd_popping", ddin, 'h102);
            end
            check("drain_addr", mem_addr, ea[k]);
            check("drain_data", mem_wdata, ea[k] + 'h100);
            tick();
        end
        mem_ack = 1'b0;
        check("drain_empty", sb_empty, 1);
        check("ovf_sticky", overflow, 1);

        // Asynchronous reset in the middle of a drain
        do_reset();
        check("rst_clr_ovf", overflow, 0);
        store('h40, 'h1);
        store('h41, 'h2);
        store('h42, 'h3);
        check("pre_rst_req", mem_req, 1);
        check("pre_rst_full", sb_full, 0);
        #2 rst = 1'b0;
        #1 check("async_req", mem_req, 0);
        check("async_empty", sb_empty, 1);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_idle", mem_req, 0);
        end

        // Repeat address to a non-head entry: merged when coalescing, queued otherwise
        store('h30, 'h1);
        store('h31, 'h2);
        store('h31, 'h3);
        daddr = 'h31;
        #1 check("coal_fwd", ddin, 'h3);
`ifdef SB_COALESCE_EN
        ea = '{'h30, 'h31};
        ed = '{'h1, 'h3};
`else
        ea = '{'h30, 'h31, 'h31};
        ed = '{'h1, 'h2, 'h3};
`endif
        mem_ack = 1'b1;
        foreach (ea[k]) begin
            check("coal_addr", mem_addr, ea[k]);
            check("coal_data", mem_wdata, ed[k]);
            tick();
        end
        mem_ack = 1'b0;
        check("coal_empty", sb_empty, 1);
        check("coal_req", mem_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
